// File: rtl/fdiv_result_pack.sv
// fdiv_result_pack
//   Output stage behind the single-precision divider core. Packs the core's
//   unpacked result fields into an IEEE-754 binary32 word, classifies it,
//   buffers it in a 2-entry skid buffer (main M + skid S) behind a
//   valid/ready handshake, and keeps sticky exception flags plus a wrapping
//   count of completed output handshakes.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       upstream handshake; in_ready = skid entry empty
//   in_sign, in_exp, in_frac  unpacked result (in_frac[23] is the hidden bit)
//   in_error, in_overflow     invalid operation / infinite quotient
//   out_valid / out_ready     downstream handshake
//   out_result                packed {sign, exp, frac[22:0]}
//   out_is_nan/inf/zero       classification of out_result
//   flag_invalid/divzero/ovf  sticky exception flags, cleared by flag_clr
//   out_count                 output handshakes since reset, wraps
module fdiv_result_pack #(
    parameter int          CNT_W     = 16,
    parameter logic [31:0] QNAN_WORD = 32'h7FC00000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [7:0]       in_exp,
    input  logic [23:0]      in_frac,
    input  logic             in_error,
    input  logic             in_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_is_nan,
    output logic             out_is_inf,
    output logic             out_is_zero,
    output logic             flag_invalid,
    output logic             flag_divzero,
    output logic             flag_ovf,
    input  logic             flag_clr,
    output logic [CNT_W-1:0] out_count
);

    // Hidden bit is dropped without a check; the core guarantees it.
    logic unused_hidden;
    assign unused_hidden = in_frac[23];

    logic        acc;
    logic        drain;
    logic [31:0] p_result;
    logic        p_nan;
    logic        p_inf;
    logic        p_zero;

    logic        s_valid;
    logic [31:0] s_result;
    logic        s_nan;
    logic        s_inf;
    logic        s_zero;

    assign in_ready = ~s_valid;
    assign acc      = in_valid & in_ready;
    assign drain    = out_valid & out_ready;

    always_comb begin
        p_result = {in_sign, in_exp, in_frac[22:0]};
        p_nan    = 1'b0;
        p_inf    = 1'b0;
        p_zero   = 1'b0;
        if (in_error) begin
            p_result = QNAN_WORD;
            p_nan    = 1'b1;
        end else if (in_exp == 8'hFF) begin
            if (in_frac[22:0] == 23'd0) begin
                p_result = {in_sign, 8'hFF, 23'd0};
                p_inf    = 1'b1;
            end else begin
                p_result = QNAN_WORD;
                p_nan    = 1'b1;
            end
        end else if (in_exp == 8'h00) begin
            // Subnormals are flushed to a signed zero.
            p_result = {in_sign, 31'd0};
            p_zero   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_result  <= 32'd0;
            out_is_nan  <= 1'b0;
            out_is_inf  <= 1'b0;
            out_is_zero <= 1'b0;
            s_valid     <= 1'b0;
            s_result    <= 32'd0;
            s_nan       <= 1'b0;
            s_inf       <= 1'b0;
            s_zero      <= 1'b0;
        end else if (drain) begin
            if (s_valid) begin
                // acc cannot happen here because in_ready is low while S is full.
                out_result  <= s_result;
                out_is_nan  <= s_nan;
                out_is_inf  <= s_inf;
                out_is_zero <= s_zero;
                s_valid     <= 1'b0;
            end else if (acc) begin
                out_result  <= p_result;
                out_is_nan  <= p_nan;
                out_is_inf  <= p_inf;
                out_is_zero <= p_zero;
            end else begin
                out_valid   <= 1'b0;
            end
        end else if (acc) begin
            if (!out_valid) begin
                out_valid   <= 1'b1;
                out_result  <= p_result;
                out_is_nan  <= p_nan;
                out_is_inf  <= p_inf;
                out_is_zero <= p_zero;
            end else begin
                // M is held by backpressure; park the new result in S.
                s_valid     <= 1'b1;
                s_result    <= p_result;
                s_nan       <= p_nan;
                s_inf       <= p_inf;
                s_zero      <= p_zero;
            end
        end
    end

    // A set in the same cycle as flag_clr wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_invalid <= 1'b0;
            flag_divzero <= 1'b0;
            flag_ovf     <= 1'b0;
        end else begin
            if (acc && in_error)
                flag_invalid <= 1'b1;
            else if (flag_clr)
                flag_invalid <= 1'b0;
            if (acc && (in_exp == 8'hFF) && !in_error && !in_overflow)
                flag_divzero <= 1'b1;
            else if (flag_clr)
                flag_divzero <= 1'b0;
            if (acc && in_overflow)
                flag_ovf <= 1'b1;
            else if (flag_clr)
                flag_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            out_count <= '0;
        else if (drain)
            out_count <= out_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_fdiv_result_pack.sv
// tb_fdiv_result_pack
//   Directed-vector bench for fdiv_result_pack (counter width 4 so the
//   wrap is reachable quickly). Inputs change 1 time unit after the rising
//   edge; outputs are sampled at the same point.
module tb_fdiv_result_pack;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             in_sign;
    logic [7:0]       in_exp;
    logic [23:0]      in_frac;
    logic             in_error;
    logic             in_overflow;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic             out_is_nan;
    logic             out_is_inf;
    logic             out_is_zero;
    logic             flag_invalid;
    logic             flag_divzero;
    logic             flag_ovf;
    logic             flag_clr;
    logic [CNT_W-1:0] out_count;

    int n_chk  = 0;
    int n_fail = 0;

    fdiv_result_pack #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_exp       (in_exp),
        .in_frac      (in_frac),
        .in_error     (in_error),
        .in_overflow  (in_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_is_nan   (out_is_nan),
        .out_is_inf   (out_is_inf),
        .out_is_zero  (out_is_zero),
        .flag_invalid (flag_invalid),
        .flag_divzero (flag_divzero),
        .flag_ovf     (flag_ovf),
        .flag_clr     (flag_clr),
        .out_count    (out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_chk++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [7:0] e, input logic [23:0] f,
                         input logic err, input logic ovf);
        in_valid    = 1'b1;
        in_sign     = s;
        in_exp      = e;
        in_frac     = f;
        in_error    = err;
        in_overflow = ovf;
    endtask

    task automatic send(input logic s, input logic [7:0] e, input logic [23:0] f,
                        input logic err, input logic ovf);
        drive(s, e, f, err, ovf);
        tick();
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] cls();
        return {29'd0, out_is_nan, out_is_inf, out_is_zero};
    endfunction

    function automatic logic [31:0] flg();
        return {29'd0, flag_invalid, flag_divzero, flag_ovf};
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = 8'd0; in_frac = 24'd0;
        in_error = 1'b0; in_overflow = 1'b0; out_ready = 1'b0; flag_clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid",  {31'd0, out_valid}, 32'd0);
        chk("rst_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_result", out_result, 32'd0);
        chk("rst_class",  cls(), 32'd0);
        chk("rst_flags",  flg(), 32'd0);
        chk("rst_count",  {28'd0, out_count}, 32'd0);

        // T1 normal
        out_ready = 1'b1;
        send(1'b1, 8'h7F, 24'hC00000, 1'b0, 1'b0);
        chk("t1_valid",  {31'd0, out_valid}, 32'd1);
        chk("t1_result", out_result, 32'hBFC00000);
        chk("t1_class",  cls(), 32'd0);
        chk("t1_count",  {28'd0, out_count}, 32'd0);

        // T2 exceptions
        send(1'b1, 8'h12, 24'h123456, 1'b1, 1'b0);
        chk("t2_err_result", out_result, 32'h7FC00000);
        chk("t2_err_class",  cls(), 32'd4);
        chk("t2_err_flags",  flg(), 32'd4);
        send(1'b0, 8'hFF, 24'h800000, 1'b0, 1'b0);
        chk("t2_dz_result", out_result, 32'h7F800000);
        chk("t2_dz_class",  cls(), 32'd2);
        chk("t2_dz_flags",  flg(), 32'd6);
        send(1'b1, 8'hFF, 24'h800000, 1'b0, 1'b1);
        chk("t2_ovf_result", out_result, 32'hFF800000);
        chk("t2_ovf_class",  cls(), 32'd2);
        chk("t2_ovf_flags",  flg(), 32'd7);
        send(1'b1, 8'h00, 24'h7FFFFF, 1'b0, 1'b0);
        chk("t2_zero_result", out_result, 32'h80000000);
        chk("t2_zero_class",  cls(), 32'd1);
        send(1'b0, 8'hFF, 24'h000001, 1'b0, 1'b0);
        chk("t2_nan_result", out_result, 32'h7FC00000);
        chk("t2_nan_class",  cls(), 32'd4);
        tick();
        chk("t2_drained", {31'd0, out_valid}, 32'd0);
        chk("t2_count",   {28'd0, out_count}, 32'd6);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        chk("clr_flags", flg(), 32'd0);

        // T3 backpressure
        out_ready = 1'b0;
        drive(1'b0, 8'h80, 24'h800000, 1'b0, 1'b0);
        tick();
        chk("t3_a_result", out_result, 32'h40000000);
        chk("t3_a_ready",  {31'd0, in_ready}, 32'd1);
        drive(1'b0, 8'h81, 24'hA00000, 1'b0, 1'b0);
        tick();
        chk("t3_b_ready",  {31'd0, in_ready}, 32'd0);
        chk("t3_b_hold",   out_result, 32'h40000000);
        drive(1'b1, 8'h7E, 24'h800000, 1'b0, 1'b0);
        tick();
        chk("t3_c_ready",  {31'd0, in_ready}, 32'd0);
        chk("t3_c_hold",   out_result, 32'h40000000);
        out_ready = 1'b1;
        tick();
        chk("t3_out_b",    out_result, 32'h40A00000);
        chk("t3_ready_up", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("t3_out_c",    out_result, 32'hBF000000);
        chk("t3_valid_c",  {31'd0, out_valid}, 32'd1);
        tick();
        chk("t3_drained",  {31'd0, out_valid}, 32'd0);
        chk("t3_count",    {28'd0, out_count}, 32'd9);

        // T4 flag set beats clear
        flag_clr = 1'b1;
        send(1'b0, 8'h40, 24'h800000, 1'b1, 1'b0);
        chk("t4_set_wins", {31'd0, flag_invalid}, 32'd1);
        tick();
        flag_clr = 1'b0;
        chk("t4_cleared",  {31'd0, flag_invalid}, 32'd0);
        chk("t4_count",    {28'd0, out_count}, 32'd10);

        // T5 reset with both entries full
        out_ready = 1'b0;
        send(1'b0, 8'h01, 24'h800000, 1'b1, 1'b0);
        send(1'b0, 8'h02, 24'h800000, 1'b0, 1'b0);
        chk("t5_full",   {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_valid",  {31'd0, out_valid}, 32'd0);
        chk("t5_ready",  {31'd0, in_ready},  32'd1);
        chk("t5_count",  {28'd0, out_count}, 32'd0);
        chk("t5_flags",  flg(), 32'd0);
        chk("t5_result", out_result, 32'd0);
        out_ready = 1'b1;
        tick();
        tick();
        chk("t5_no_stale", {31'd0, out_valid}, 32'd0);
        chk("t5_count2",   {28'd0, out_count}, 32'd0);

        // T6 counter wrap with CNT_W=4
        drive(1'b0, 8'h85, 24'h900000, 1'b0, 1'b0);
        for (int i = 1; i <= 17; i++) begin
            tick();
            if (i == 17)
                chk("t6_wrap0", {28'd0, out_count}, 32'd0);
        end
        in_valid = 1'b0;
        tick();
        chk("t6_count", {28'd0, out_count}, 32'd1);
        chk("t6_idle",  {31'd0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
